// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the shift/rotate sequencer.
// Optional abort support is selected with SHSEQ_ABORT_EN.
package shift_pkg;

    localparam logic [2:0] SHOP_SHL  = 3'b000;
    localparam logic [2:0] SHOP_SHR  = 3'b001;
    localparam logic [2:0] SHOP_SHRA = 3'b010;
    localparam logic [2:0] SHOP_ROL  = 3'b011;
    localparam logic [2:0] SHOP_ROR  = 3'b100;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_DONE = 2'b10
    } seq_state_e;

    function automatic logic shop_legal(input logic [2:0] op);
        return op <= SHOP_ROR;
    endfunction

endpackage

// File: rtl/shift_rotate_seq_if.sv
// Request/response bundle between the control unit and the shift/rotate sequencer.
// The abort signal exists only when SHSEQ_ABORT_EN is defined.
interface shift_rotate_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
`ifdef SHSEQ_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] result;

`ifdef SHSEQ_ABORT_EN
    modport master (
        output start, op, operand, amount, abort,
        input  ready, busy, done, illegal, result
    );
    modport slave (
        input  start, op, operand, amount, abort,
        output ready, busy, done, illegal, result
    );
`else
    modport master (
        output start, op, operand, amount,
        input  ready, busy, done, illegal, result
    );
    modport slave (
        input  start, op, operand, amount,
        output ready, busy, done, illegal, result
    );
`endif

endinterface

// File: rtl/shift_step.sv
// Combinational single-cycle step: shifts/rotates the work value by k (0..STEP) positions.
// Unaffected by SHSEQ_ABORT_EN.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned K_W  = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_work,
    input  logic [2:0]       i_op,
    input  logic [K_W-1:0]   i_k,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_work
);

    logic [WIDTH-1:0] w_val;

    always_comb begin
        w_val = i_work;
        for (int i = 0; i < int'(STEP); i++) begin
            if (K_W'(i) < i_k) begin
                case (i_op)
                    SHOP_SHL:  w_val = {w_val[WIDTH-2:0], 1'b0};
                    SHOP_SHR:  w_val = {1'b0, w_val[WIDTH-1:1]};
                    SHOP_SHRA: w_val = {i_sign, w_val[WIDTH-1:1]};
                    SHOP_ROL:  w_val = {w_val[WIDTH-2:0], w_val[WIDTH-1]};
                    SHOP_ROR:  w_val = {w_val[0], w_val[WIDTH-1:1]};
                    default:   w_val = w_val;
                endcase
            end
        end
        o_work = w_val;
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate sequencer: IDLE -> RUN -> DONE, STEP bit positions per RUN cycle.
// Define SHSEQ_ABORT_EN to enable cancelling an operation while in RUN.
module shift_rotate_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5,
    parameter int unsigned STEP  = 1
) (
    input logic              clk,
    input logic              reset,
    shift_rotate_seq_if.slave bus
);

    localparam int unsigned K_W = $clog2(STEP + 1);

    seq_state_e       r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic [AMT_W-1:0] r_rem;
    logic [2:0]       r_op;
    logic             r_sign;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_illegal;

    logic [K_W-1:0]   w_k;
    logic [WIDTH-1:0] w_work_next;
    logic             w_abort;
    logic             w_legal;

`ifdef SHSEQ_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_legal = shop_legal(bus.op);
    // k = min(STEP, remaining)
    assign w_k     = (r_rem >= AMT_W'(STEP)) ? K_W'(STEP) : K_W'(r_rem);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_work (r_work),
        .i_op   (r_op),
        .i_k    (w_k),
        .i_sign (r_sign),
        .o_work (w_work_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SEQ_IDLE;
            r_work    <= '0;
            r_result  <= '0;
            r_rem     <= '0;
            r_op      <= '0;
            r_sign    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                SEQ_IDLE: begin
                    if (bus.start) begin
                        r_work  <= bus.operand;
                        r_rem   <= bus.amount;
                        r_op    <= bus.op;
                        r_sign  <= bus.operand[WIDTH-1];
                        r_ready <= 1'b0;
                        // Nothing to iterate: go straight to DONE with the operand as result
                        if (bus.amount == '0 || !w_legal) begin
                            r_state   <= SEQ_DONE;
                            r_done    <= 1'b1;
                            r_illegal <= !w_legal;
                            r_result  <= bus.operand;
                        end else begin
                            r_state <= SEQ_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (w_abort) begin
                        r_state <= SEQ_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_work <= w_work_next;
                        r_rem  <= r_rem - AMT_W'(w_k);
                        if (r_rem == AMT_W'(w_k)) begin
                            r_state  <= SEQ_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_work_next;
                        end
                    end
                end
                SEQ_DONE: begin
                    r_state   <= SEQ_IDLE;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state   <= SEQ_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.illegal = r_illegal;
    assign bus.result  = r_result;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Scoreboard bench for shift_rotate_seq with STEP=1 and STEP=4 instances.
// Abort scenario is exercised only when SHSEQ_ABORT_EN is defined.
module tb_shift_rotate_seq;
    import shift_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int unsigned cyc;
        int unsigned nb;
    } exp_t;

    logic clk;
    logic reset;
    int unsigned cyc;
    int n_tests;
    int n_fail;
    exp_t q1[$];
    exp_t q4[$];
    logic [31:0] last1;
    logic [31:0] last4;
    int unsigned bc1, bc4, dc1, dc4;

    shift_rotate_seq_if #(.WIDTH(32), .AMT_W(5)) if1 ();
    shift_rotate_seq_if #(.WIDTH(32), .AMT_W(5)) if4 ();

    shift_rotate_seq #(.WIDTH(32), .AMT_W(5), .STEP(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    shift_rotate_seq #(.WIDTH(32), .AMT_W(5), .STEP(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input int unsigned n);
        case (op)
            SHOP_SHL:  return a << n;
            SHOP_SHR:  return a >> n;
            SHOP_SHRA: return $unsigned($signed(a) >>> n);
            SHOP_ROL:  return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
            SHOP_ROR:  return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
            default:   return a;
        endcase
    endfunction

    task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [4:0] amt);
        int unsigned step;
        int unsigned n;
        int w;
        logic legal;
        exp_t e;
        step  = (sel == 4) ? 4 : 1;
        legal = (op <= SHOP_ROR);
        w = 0;
        @(negedge clk);
        while (!((sel == 4) ? if4.ready : if1.ready) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        n = (!legal || amt == 0) ? 0 : (int'(amt) + step - 1) / step;
        e.res = legal ? model(op, a, int'(amt)) : a;
        e.ill = !legal;
        e.cyc = cyc + 1 + n;
        e.nb  = n;
        if (sel == 4) begin
            if4.start = 1'b1; if4.op = op; if4.operand = a; if4.amount = amt;
            q4.push_back(e);
        end else begin
            if1.start = 1'b1; if1.op = op; if1.operand = a; if1.amount = amt;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        if4.start = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q1.size() != 0 || q4.size() != 0) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(q1.size() + q4.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if1.ready) bc1 = 0;
        if (if1.busy) begin
            bc1++;
            check("dut1_result_hold", if1.result, last1);
        end
        if (if1.done) begin
            dc1++;
            if (q1.size() == 0) begin
                check("dut1_spurious_done", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_result", if1.result, e.res);
                check("dut1_illegal", if1.illegal, e.ill);
                check("dut1_done_cycle", cyc, e.cyc);
                check("dut1_busy_cycles", bc1, e.nb);
                last1 = e.res;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if4.ready) bc4 = 0;
        if (if4.busy) begin
            bc4++;
            check("dut4_result_hold", if4.result, last4);
        end
        if (if4.done) begin
            dc4++;
            if (q4.size() == 0) begin
                check("dut4_spurious_done", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                check("dut4_result", if4.result, e.res);
                check("dut4_illegal", if4.illegal, e.ill);
                check("dut4_done_cycle", cyc, e.cyc);
                check("dut4_busy_cycles", bc4, e.nb);
                last4 = e.res;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned saved;
        n_tests = 0; n_fail = 0; cyc = 0;
        last1 = '0; last4 = '0;
        bc1 = 0; bc4 = 0; dc1 = 0; dc4 = 0;
        if1.start = 1'b0; if1.op = '0; if1.operand = '0; if1.amount = '0;
        if4.start = 1'b0; if4.op = '0; if4.operand = '0; if4.amount = '0;
`ifdef SHSEQ_ABORT_EN
        if1.abort = 1'b0;
        if4.abort = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready1", if1.ready, 1'b1);
        check("rst_busy1", if1.busy, 1'b0);
        check("rst_done1", if1.done, 1'b0);
        check("rst_illegal1", if1.illegal, 1'b0);
        check("rst_result1", if1.result, 32'h0);
        check("rst_ready4", if4.ready, 1'b1);
        check("rst_result4", if4.result, 32'h0);
        reset = 1'b0;

        issue(1, SHOP_ROL, 32'h8000_0001, 5'd1);
        drain();

        // Start pulses during a long run must be ignored
        issue(1, SHOP_ROR, 32'h0000_0001, 5'd31);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if1.start = 1'b1; if1.op = SHOP_SHL; if1.operand = 32'hDEAD_BEEF; if1.amount = 5'd3;
            @(negedge clk);
            if1.start = 1'b0;
        end
        drain();

        issue(4, SHOP_SHRA, 32'h8000_0000, 5'd6);
        drain();

        issue(1, SHOP_SHL, 32'h1234_5678, 5'd0);
        issue(1, 3'b111, 32'hCAFE_F00D, 5'd9);
        issue(4, 3'b101, 32'h0BAD_0BAD, 5'd0);
        issue(4, SHOP_ROL, 32'hF000_000F, 5'd7);
        drain();

        for (int i = 0; i < 24; i++) begin
            issue((i % 2 == 0) ? 1 : 4, 3'($urandom_range(0, 5)), $urandom, 5'($urandom_range(0, 31)));
        end
        drain();

        // Asynchronous reset mid-RUN kills the op without a done pulse
        issue(1, SHOP_ROR, 32'h1357_9BDF, 5'd20);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_ready", if1.ready, 1'b1);
        check("midrst_busy", if1.busy, 1'b0);
        check("midrst_result", if1.result, 32'h0);
        q1.delete();
        last1 = '0; last4 = '0;
        saved = dc1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", dc1, saved);

        issue(1, SHOP_SHR, 32'hF0F0_F0F0, 5'd4);
        drain();

`ifdef SHSEQ_ABORT_EN
        issue(1, SHOP_ROL, 32'h0000_00F0, 5'd10);
        saved = dc1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        if1.abort = 1'b1;
        @(posedge clk);
        #1;
        if1.abort = 1'b0;
        check("abort_ready", if1.ready, 1'b1);
        check("abort_busy", if1.busy, 1'b0);
        check("abort_result", if1.result, last1);
        q1.delete();
        repeat (15) @(negedge clk);
        check("abort_no_done", dc1, saved);
        issue(1, SHOP_SHL, 32'h0000_0001, 5'd5);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
